// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM encodings and the
// counter width it shares with the threshold-driven clock divider.
package pulse_period_meter_pkg;

    localparam int PPM_W = 26;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_MEAS  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARMED = ST_ARMED,
        MEAS  = ST_MEAS
    } state_t;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Control and result signals of the pulse period meter; the block sits on the
// slave side, whoever drives the pulse train and reference sits on the master side.
interface pulse_period_meter_if
    import pulse_period_meter_pkg::*;
#(
    parameter int W = PPM_W
);
    logic         enable;
    logic         pulse_in;
    logic [W-1:0] expected;
    logic [W-1:0] period_out;
    logic         period_valid;
    logic         in_range;
    logic         timeout;

    modport master (
        output enable, pulse_in, expected,
        input  period_out, period_valid, in_range, timeout
    );

    modport slave (
        input  enable, pulse_in, expected,
        output period_out, period_valid, in_range, timeout
    );
endinterface

// File: rtl/pulse_period_meter_rise.sv
// Registered rising-edge detector: rise is high in the cycle the input first
// goes high, using the input's value from the previous clock.
module rise_detect (
    input  logic default_clk,
    input  logic resetn,
    input  logic in,
    output logic rise
);
    logic prev;

    always_ff @(posedge default_clk) begin
        if (!resetn) prev <= 1'b0;
        else         prev <= in;
    end

    assign rise = in & ~prev;
endmodule

// File: rtl/pulse_period_meter.sv
// Measures the distance in clocks between consecutive rising edges of a pulse
// train, checks it against a reference, and flags a stalled source.
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int W   = PPM_W,
    parameter int TOL = 0
) (
    input  logic                 default_clk,
    input  logic                 resetn,
    pulse_period_meter_if.slave  bus
);
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);
    localparam logic [W:0]   TOL_W   = (W+1)'(TOL);

    logic         rise;
    state_t       state, state_nxt;
    logic [W-1:0] counter, counter_nxt;
    logic [W-1:0] period_q, period_nxt;
    logic         valid_q, valid_nxt;
    logic         inr_q, inr_nxt;
    logic         to_q, to_nxt;

    logic [W:0]   cnt_x, exp_x, diff;
    logic         in_range_now;

    rise_detect u_rise (
        .default_clk (default_clk),
        .resetn      (resetn),
        .in          (bus.pulse_in),
        .rise        (rise)
    );

    // One extra bit so the difference can never wrap.
    assign cnt_x        = {1'b0, counter};
    assign exp_x        = {1'b0, bus.expected};
    assign diff         = (cnt_x >= exp_x) ? (cnt_x - exp_x) : (exp_x - cnt_x);
    assign in_range_now = (diff <= TOL_W);

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        period_nxt  = period_q;
        valid_nxt   = 1'b0;
        inr_nxt     = inr_q;
        to_nxt      = to_q;
        if (!bus.enable) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
            to_nxt      = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    counter_nxt = '0;
                    state_nxt   = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        counter_nxt = CNT_ONE;
                        state_nxt   = MEAS;
                    end
                end
                MEAS: begin
                    // A rise on the saturated count is still a valid period.
                    if (rise) begin
                        period_nxt  = counter;
                        valid_nxt   = 1'b1;
                        inr_nxt     = in_range_now;
                        to_nxt      = 1'b0;
                        counter_nxt = CNT_ONE;
                    end else if (counter == CNT_MAX) begin
                        to_nxt      = 1'b1;
                        counter_nxt = '0;
                        state_nxt   = ARMED;
                    end else begin
                        counter_nxt = counter + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge default_clk) begin
        if (!resetn) begin
            state    <= IDLE;
            counter  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            inr_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            counter  <= counter_nxt;
            period_q <= period_nxt;
            valid_q  <= valid_nxt;
            inr_q    <= inr_nxt;
            to_q     <= to_nxt;
        end
    end

    assign bus.period_out   = period_q;
    assign bus.period_valid = valid_q;
    assign bus.in_range     = inr_q;
    assign bus.timeout      = to_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: three instances (W=26 TOL=0, W=26 TOL=2,
// W=4 TOL=0) share one stimulus and are checked every cycle against an edge-time model.
module tb_pulse_period_meter;
    logic        default_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic        pin = 1'b0;
    logic [25:0] exp_v = '0;

    always #5 default_clk = ~default_clk;

    pulse_period_meter_if #(.W(26)) if0 ();
    pulse_period_meter_if #(.W(26)) if2 ();
    pulse_period_meter_if #(.W(4))  if4 ();

    assign if0.enable = en;  assign if0.pulse_in = pin;  assign if0.expected = exp_v;
    assign if2.enable = en;  assign if2.pulse_in = pin;  assign if2.expected = exp_v;
    assign if4.enable = en;  assign if4.pulse_in = pin;  assign if4.expected = exp_v[3:0];

    pulse_period_meter #(.W(26), .TOL(0)) u0 (.default_clk(default_clk), .resetn(resetn), .bus(if0));
    pulse_period_meter #(.W(26), .TOL(2)) u2 (.default_clk(default_clk), .resetn(resetn), .bus(if2));
    pulse_period_meter #(.W(4),  .TOL(0)) u4 (.default_clk(default_clk), .resetn(resetn), .bus(if4));

    logic [63:0] d_p [3];
    logic        d_v [3];
    logic        d_r [3];
    logic        d_t [3];
    assign d_p[0] = 64'(if0.period_out); assign d_v[0] = if0.period_valid;
    assign d_r[0] = if0.in_range;        assign d_t[0] = if0.timeout;
    assign d_p[1] = 64'(if2.period_out); assign d_v[1] = if2.period_valid;
    assign d_r[1] = if2.in_range;        assign d_t[1] = if2.timeout;
    assign d_p[2] = 64'(if4.period_out); assign d_v[2] = if4.period_valid;
    assign d_r[2] = if4.in_range;        assign d_t[2] = if4.timeout;

    int checks = 0;
    int errors = 0;
    int sc [3] = '{0, 0, 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Model: a period is the number of clocks between the edge that armed the
    // measurement and the next rising edge; a stall of 2^W-1 clocks is a timeout.
    longint      maxc [3] = '{67108863, 67108863, 15};
    longint      tol  [3] = '{0, 2, 0};
    longint      m_last [3];
    bit          m_idle [3] = '{1, 1, 1};
    bit          m_arm  [3] = '{0, 0, 0};
    logic [63:0] m_p [3] = '{0, 0, 0};
    bit          m_v [3] = '{0, 0, 0};
    bit          m_r [3] = '{0, 0, 0};
    bit          m_t [3] = '{0, 0, 0};

    initial begin
        longint cyc;
        bit     prev, rn, e, p, rise;
        longint x, el, dd;
        cyc  = 0;
        prev = 0;
        forever begin
            @(posedge default_clk);
            rn = resetn; e = en; p = pin; x = longint'(exp_v);
            cyc++;
            rise = p & ~prev;
            prev = rn ? p : 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!rn) begin
                    m_idle[i] = 1; m_arm[i] = 0;
                    m_p[i] = 0; m_v[i] = 0; m_r[i] = 0; m_t[i] = 0;
                end else if (!e) begin
                    m_idle[i] = 1; m_arm[i] = 0; m_v[i] = 0; m_t[i] = 0;
                end else if (m_idle[i]) begin
                    m_idle[i] = 0; m_arm[i] = 0; m_v[i] = 0;
                end else begin
                    m_v[i] = 0;
                    el = cyc - m_last[i];
                    if (rise) begin
                        if (m_arm[i]) begin
                            dd = el - (x & maxc[i]);
                            if (dd < 0) dd = -dd;
                            m_p[i] = 64'(el); m_v[i] = 1; m_r[i] = (dd <= tol[i]); m_t[i] = 0;
                        end
                        m_arm[i] = 1; m_last[i] = cyc;
                    end else if (m_arm[i] && el == maxc[i]) begin
                        m_t[i] = 1; m_arm[i] = 0;
                    end
                end
            end
            #2;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_period_out", i), d_p[i], m_p[i]);
                chk($sformatf("u%0d_period_valid", i), 64'(d_v[i]), 64'(m_v[i]));
                chk($sformatf("u%0d_in_range", i), 64'(d_r[i]), 64'(m_r[i]));
                chk($sformatf("u%0d_timeout", i), 64'(d_t[i]), 64'(m_t[i]));
                if (d_v[i] === 1'b1) sc[i]++;
            end
        end
    end

    task automatic pulse_train(input int per, input int n);
        for (int k = 0; k < n; k++) begin
            pin = 1'b1;
            @(negedge default_clk);
            pin = 1'b0;
            repeat (per - 1) @(negedge default_clk);
        end
    endtask

    initial begin
        int base;
        repeat (2) @(negedge default_clk);
        chk("reset_period", 64'(if0.period_out), 0);
        chk("reset_valid", 64'(if4.period_valid), 0);
        chk("reset_timeout", 64'(if0.timeout), 0);

        // Divider threshold 5: first edge only arms, then one strobe per edge.
        resetn = 1'b1; en = 1'b1; exp_v = 26'd5;
        @(negedge default_clk);
        base = sc[0];
        pulse_train(5, 5);
        chk("t1_strobes", 64'(sc[0] - base), 4);
        chk("t1_period", 64'(if0.period_out), 5);
        chk("t1_in_range", 64'(if0.in_range), 1);

        // Range checks in both subtraction directions.
        exp_v = 26'd7;
        pulse_train(5, 3);
        chk("t2_exp7_tol0", 64'(if0.in_range), 0);
        chk("t2_exp7_tol2", 64'(if2.in_range), 1);
        exp_v = 26'd3;
        pulse_train(5, 3);
        chk("t2_exp3_tol2", 64'(if2.in_range), 1);
        chk("t2_exp3_tol0", 64'(if0.in_range), 0);

        // Stall long enough to saturate the 4-bit counter, then recover.
        repeat (20) @(negedge default_clk);
        chk("t3_timeout_w4", 64'(if4.timeout), 1);
        chk("t3_timeout_w26", 64'(if0.timeout), 0);
        pin = 1'b1; @(negedge default_clk); pin = 1'b0;
        repeat (5) @(negedge default_clk);
        pin = 1'b1; @(negedge default_clk); pin = 1'b0;
        repeat (3) @(negedge default_clk);
        chk("t3_period_w4", 64'(if4.period_out), 6);
        chk("t3_timeout_clr", 64'(if4.timeout), 0);

        // Enable drop mid-interval: first edge after re-enable only arms.
        exp_v = 26'd10;
        pulse_train(10, 3);
        pin = 1'b1; @(negedge default_clk); pin = 1'b0;
        repeat (3) @(negedge default_clk);
        en = 1'b0;
        repeat (3) @(negedge default_clk);
        en = 1'b1;
        base = sc[0];
        repeat (2) @(negedge default_clk);
        pulse_train(10, 2);
        chk("t4_strobes", 64'(sc[0] - base), 1);
        chk("t4_period", 64'(if0.period_out), 10);
        chk("t4_in_range", 64'(if0.in_range), 1);

        // One-cycle reset mid-measurement.
        exp_v = 26'd8;
        pulse_train(8, 3);
        pin = 1'b1; @(negedge default_clk); pin = 1'b0;
        repeat (3) @(negedge default_clk);
        resetn = 1'b0;
        @(negedge default_clk);
        chk("t5_rst_period", 64'(if0.period_out), 0);
        chk("t5_rst_valid", 64'(if0.period_valid), 0);
        chk("t5_rst_in_range", 64'(if0.in_range), 0);
        chk("t5_rst_period_w4", 64'(if4.period_out), 0);
        resetn = 1'b1;
        repeat (2) @(negedge default_clk);
        base = sc[0];
        pulse_train(8, 3);
        chk("t5_strobes", 64'(sc[0] - base), 2);
        chk("t5_period", 64'(if0.period_out), 8);

        // Input stuck high: a single rise, then saturation on the narrow counter.
        en = 1'b0;
        repeat (2) @(negedge default_clk);
        en = 1'b1;
        repeat (2) @(negedge default_clk);
        base = sc[2];
        pin = 1'b1;
        repeat (40) @(negedge default_clk);
        pin = 1'b0;
        repeat (2) @(negedge default_clk);
        chk("t6_timeout_w4", 64'(if4.timeout), 1);
        chk("t6_strobes_w4", 64'(sc[2] - base), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Measures the interval, in default_clk cycles, between consecutive rising edges of a pulse train, such as the one-cycle pulses from the threshold-driven clock divider.
- It is the inverse of that divider: the divider turns a threshold into a pulse train, and this block recovers the threshold from the pulse train.
- Used for self-check of divider settings, speed readout on HEX displays, and detecting a stalled tick source.
- Sits beside the divider in the default_clk domain.

Parameters:
- W, 26, width of the period counter and of period_out; matches the divider threshold width.
- TOL, 0, allowed absolute difference between a measured period and expected for in_range to assert.

Ports:
- default_clk  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- pulse_in  input  1  pulse train; already synchronous to default_clk.
- expected  input  W  reference period for the range check.
- period_out  output  W  last completed period measurement.
- period_valid  output  1  one-cycle strobe; period_out and in_range updated this cycle.
- in_range  output  1  |period_out - expected| <= TOL, registered together with period_out.
- timeout  output  1  sticky: counter saturated with no edge.

Behaviour:
- Clocking and reset: one clock, default_clk. Reset is synchronous and active-low on resetn; polarity and synchronicity are fixed. While resetn=0 at a clock edge, every register is cleared:
  - period_out=0, period_valid=0, in_range=0, timeout=0
  - counter=0, prev_pulse=0, state=IDLE
- Edge detect: rise = pulse_in & ~prev_pulse; prev_pulse <= pulse_in every cycle, including in IDLE.
- States:
  - IDLE: counter=0. Go to ARMED when enable=1.
  - ARMED: waiting for the first edge. On rise: counter<=1, go to MEAS. No output strobe.
  - MEAS: each cycle without rise, counter<=counter+1.
    - On rise: period_out<=counter, period_valid<=1, in_range<=range check, timeout<=0, counter<=1, stay in MEAS.
- Period definition: edges at cycles k and k+T give period_out=T. A divider with threshold T (T>=2) yields T.
- Latency: period_valid is high in the cycle after the cycle in which rise is detected. It is high for exactly one cycle per measured interval.
- Saturation:
  - In MEAS, if counter==2^W-1 and there is no rise: timeout<=1, counter<=0, go to ARMED. period_out holds.
  - Rise in the same cycle counter==2^W-1: this is a normal measurement. period_out=2^W-1, no timeout.
- enable=0 in any state: next state IDLE, counter<=0, period_valid<=0, timeout<=0. period_out and in_range hold.
  - On re-enable the first edge only arms; no stale measurement is reported.
- pulse_in held high continuously gives only one rise, so the block eventually times out.
- Range check: compute the absolute difference in W+1 bits, no wrap, then compare with TOL.
- Reset mid-MEAS: all registers cleared at that edge. Measurement resumes from ARMED once resetn=1 and enable=1.
- period_valid is 0 whenever it is not explicitly strobed.

Decomposition:
- Shared package holds:
  - state encodings IDLE/ARMED/MEAS (2-bit localparams)
  - default counter width 26, shared with the divider
- One sub-module, rise_detect: a registered rising-edge detector with synchronous active-low reset.
  - Ports: default_clk, resetn, in, rise.
  - Reusable for key and tick edges elsewhere in the design.

Test Plan:
1. enable=1, pulse_in high one cycle every 5 cycles (divider threshold 5) -> no strobe after the first edge. Each later edge gives period_valid one cycle later with period_out=5, repeating every 5 cycles.
2. Same stimulus, expected=5, TOL=0 -> in_range=1. expected=7, TOL=0 -> in_range=0. expected=7, TOL=2 -> in_range=1. expected=3, TOL=2 -> in_range=1, which checks the subtraction direction.
3. W=4 override, single edge at cycle k, no further edges -> timeout=1 from cycle k+16 onward with period_valid never set. The next two edges, 6 cycles apart, give period_out=6 and timeout=0.
4. Period 10 running, drop enable mid-interval for 3 cycles, then re-enable -> no period_valid at the next edge, which only arms. A valid period_out=10 appears at the second edge after re-enable.
5. resetn=0 for one cycle mid-measurement -> at that edge all outputs are 0 and state is IDLE. With enable=1, measurement restarts and the first reported period equals the true period.
6. pulse_in held at 1 for 40 cycles with W=4 -> one rise only, then timeout=1 after saturation; no period_valid.
